// File: rtl/cfg_regscan.sv
// cfg_regscan: walks a fixed list of PCIe configuration addresses through the
// cfg_mgmt port. Each entry is read, flagged if it reads zero, optionally
// written back with the value just read, and every strobe is bounded by a
// timeout. The scan reports a per-entry fail mask and an overall pass flag.
module cfg_regscan #(
    parameter int                     NUM_REGS   = 4,
    parameter logic [19*NUM_REGS-1:0] ADDR_LIST  = {19'd60, 19'd16, 19'd4, 19'd0},
    parameter bit                     WRITE_BACK = 1'b1,
    parameter int                     TIMEOUT    = 1023
) (
    input  logic                usr_clk,
    input  logic                usr_rst_n,
    output logic [18:0]         cfg_mgmt_addr_o,
    output logic                cfg_mgmt_write_o,
    output logic [31:0]         cfg_mgmt_write_data_o,
    output logic [3:0]          cfg_mgmt_byte_enable_o,
    output logic                cfg_mgmt_read_o,
    input  logic [31:0]         cfg_mgmt_read_data_i,
    input  logic                cfg_mgmt_read_write_done_i,
    output logic                cfg_mgmt_type1_cfg_reg_access_o,
    input  logic                cfg_scan_run_i,
    output logic                scan_busy_o,
    output logic                scan_done_o,
    output logic                scan_pass_o,
    output logic [NUM_REGS-1:0] fail_mask_o,
    output logic                scan_timeout_o,
    output logic [31:0]         last_rd_data_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [18:0]      FIRST_ADDR = ADDR_LIST[18:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q;
    logic               run_rise, run_fall;
    logic               access_expired;

    logic               rd_d;
    logic               wr_d;
    logic [31:0]        wdata_d;
    logic [18:0]        addr_d;
    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic [NUM_REGS-1:0] fail_d;
    logic               tmo_d;
    logic [31:0]        last_d;

    // Address of list entry i.
    function automatic logic [18:0] entry_addr(input logic [IDX_W-1:0] i);
        return ADDR_LIST[19*int'(i) +: 19];
    endfunction

    // Edges of the run request, judged against last cycle's sampled level.
    assign run_rise = cfg_scan_run_i & ~run_q;
    assign run_fall = ~cfg_scan_run_i & run_q;

    // The current strobe has been high for TIMEOUT-1 cycles; this cycle is its last.
    assign access_expired = (cnt_q == CNT_LIMIT);

    // Byte enables follow the write strobe; only full-dword write-backs are issued.
    assign cfg_mgmt_byte_enable_o = cfg_mgmt_write_o ? 4'hF : 4'h0;

    // Only type-0 accesses to the local function are ever generated.
    assign cfg_mgmt_type1_cfg_reg_access_o = 1'b0;

    // Registers the run level for edge detection.
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= cfg_scan_run_i;
        end
    end

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rd_d    = cfg_mgmt_read_o;
        wr_d    = cfg_mgmt_write_o;
        wdata_d = cfg_mgmt_write_data_o;
        addr_d  = cfg_mgmt_addr_o;
        busy_d  = scan_busy_o;
        done_d  = 1'b0;
        pass_d  = scan_pass_o;
        fail_d  = fail_mask_o;
        tmo_d   = scan_timeout_o;
        last_d  = last_rd_data_o;

        unique case (state_q)
            S_IDLE: begin
                if (run_rise) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    addr_d  = FIRST_ADDR;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = '0;
                    tmo_d   = 1'b0;
                end
            end

            S_READ: begin
                if (!cfg_mgmt_read_o) begin
                    // First cycle in READ: raise the strobe, start the timeout window.
                    rd_d  = 1'b1;
                    cnt_d = '0;
                end else if (cfg_mgmt_read_write_done_i) begin
                    rd_d    = 1'b0;
                    wdata_d = cfg_mgmt_read_data_i;
                    last_d  = cfg_mgmt_read_data_i;
                    if (cfg_mgmt_read_data_i == 32'd0) begin
                        fail_d[idx_q] = 1'b1;
                    end
                    state_d = WRITE_BACK ? S_WRITE : S_NEXT;
                end else if (access_expired) begin
                    // Read never completed: skip the write-back for this entry.
                    rd_d          = 1'b0;
                    fail_d[idx_q] = 1'b1;
                    tmo_d         = 1'b1;
                    state_d       = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WRITE: begin
                if (!cfg_mgmt_write_o) begin
                    wr_d  = 1'b1;
                    cnt_d = '0;
                end else if (cfg_mgmt_read_write_done_i) begin
                    wr_d    = 1'b0;
                    state_d = S_NEXT;
                end else if (access_expired) begin
                    wr_d          = 1'b0;
                    fail_d[idx_q] = 1'b1;
                    tmo_d         = 1'b1;
                    state_d       = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    // Completion: done pulse and pass flag land together, busy drops.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = ~|fail_mask_o;
                    busy_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = entry_addr(idx_q + 1'b1);
                    state_d = S_READ;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                addr_d  = FIRST_ADDR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outranks a completion or timeout seen in the same cycle; the
        // partial fail mask and timeout flag are left for inspection.
        if (run_fall && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            addr_d  = FIRST_ADDR;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = scan_pass_o;
            fail_d  = fail_mask_o;
            tmo_d   = scan_timeout_o;
            last_d  = last_rd_data_o;
            wdata_d = cfg_mgmt_write_data_o;
        end
    end

    // Sequencer state, entry index and access timeout counter.
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered cfg_mgmt strobes, address and write-back data.
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            cfg_mgmt_read_o       <= 1'b0;
            cfg_mgmt_write_o      <= 1'b0;
            cfg_mgmt_write_data_o <= 32'd0;
            cfg_mgmt_addr_o       <= FIRST_ADDR;
        end else begin
            cfg_mgmt_read_o       <= rd_d;
            cfg_mgmt_write_o      <= wr_d;
            cfg_mgmt_write_data_o <= wdata_d;
            cfg_mgmt_addr_o       <= addr_d;
        end
    end

    // Registered scan status seen by the application logic.
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            scan_busy_o    <= 1'b0;
            scan_done_o    <= 1'b0;
            scan_pass_o    <= 1'b0;
            fail_mask_o    <= '0;
            scan_timeout_o <= 1'b0;
            last_rd_data_o <= 32'd0;
        end else begin
            scan_busy_o    <= busy_d;
            scan_done_o    <= done_d;
            scan_pass_o    <= pass_d;
            fail_mask_o    <= fail_d;
            scan_timeout_o <= tmo_d;
            last_rd_data_o <= last_d;
        end
    end

endmodule

// File: tb/tb_cfg_regscan.sv
// Bench for cfg_regscan: two instances (write-back on / off, TIMEOUT=8), a
// behavioural cfg_mgmt completer, a strobe monitor and a scan-level model.
`timescale 1ns/1ps
module tb_cfg_regscan;

    localparam int TMO = 8;
    localparam logic [75:0] LIST_A = {19'd60, 19'd16, 19'd4, 19'd0};
    localparam logic [75:0] LIST_B = {19'd12, 19'd16, 19'd4, 19'd8};

    logic        usr_clk;
    logic        usr_rst_n;
    logic [18:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        done  [2];
    logic        type1 [2];
    logic        run   [2];
    logic        busy  [2];
    logic        sdone [2];
    logic        pass  [2];
    logic [3:0]  mask  [2];
    logic        tmo   [2];
    logic [31:0] last  [2];

    cfg_regscan #(.NUM_REGS(4), .ADDR_LIST(LIST_A), .WRITE_BACK(1'b1), .TIMEOUT(TMO)) dut_a (
        .usr_clk(usr_clk), .usr_rst_n(usr_rst_n),
        .cfg_mgmt_addr_o(addr[0]), .cfg_mgmt_write_o(wr[0]), .cfg_mgmt_write_data_o(wdata[0]),
        .cfg_mgmt_byte_enable_o(be[0]), .cfg_mgmt_read_o(rd[0]), .cfg_mgmt_read_data_i(rdata[0]),
        .cfg_mgmt_read_write_done_i(done[0]), .cfg_mgmt_type1_cfg_reg_access_o(type1[0]),
        .cfg_scan_run_i(run[0]), .scan_busy_o(busy[0]), .scan_done_o(sdone[0]),
        .scan_pass_o(pass[0]), .fail_mask_o(mask[0]), .scan_timeout_o(tmo[0]),
        .last_rd_data_o(last[0]));

    cfg_regscan #(.NUM_REGS(4), .ADDR_LIST(LIST_B), .WRITE_BACK(1'b0), .TIMEOUT(TMO)) dut_b (
        .usr_clk(usr_clk), .usr_rst_n(usr_rst_n),
        .cfg_mgmt_addr_o(addr[1]), .cfg_mgmt_write_o(wr[1]), .cfg_mgmt_write_data_o(wdata[1]),
        .cfg_mgmt_byte_enable_o(be[1]), .cfg_mgmt_read_o(rd[1]), .cfg_mgmt_read_data_i(rdata[1]),
        .cfg_mgmt_read_write_done_i(done[1]), .cfg_mgmt_type1_cfg_reg_access_o(type1[1]),
        .cfg_scan_run_i(run[1]), .scan_busy_o(busy[1]), .scan_done_o(sdone[1]),
        .scan_pass_o(pass[1]), .fail_mask_o(mask[1]), .scan_timeout_o(tmo[1]),
        .last_rd_data_o(last[1]));

    typedef struct {
        bit          w;
        logic [18:0] a;
        logic [31:0] d;
        int          dur;
        bit          cl;
    } txn_t;

    typedef struct {
        int              k;
        logic [3:0][31:0] d;
        logic [3:0][3:0]  rl;
        logic [3:0][3:0]  wl;
        bit              spur;
        logic [3:0]      emask;
        bit              epass;
        bit              etmo;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [18:0] alist [2][4];
    logic [31:0] cd    [2][4];
    int          crl   [2][4];
    int          cwl   [2][4];
    bit          spur  [2];
    bit          wb    [2];
    logic [31:0] exp_last [2];
    txn_t        ex    [2][8];
    int          ex_n  [2];
    int          got_n [2];
    int          done_cnt [2];
    int          done_cyc [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input int k, input logic [18:0] a);
        for (int i = 0; i < 4; i++) if (alist[k][i] == a) return i;
        return 0;
    endfunction

    function automatic void add_txn(input int k, input bit w, input logic [18:0] a,
                                    input logic [31:0] d, input int dur, input bit cl);
        ex[k][ex_n[k]] = '{w, a, d, dur, cl};
        ex_n[k]++;
    endfunction

    // Expected strobes for the first nent entries; returns the scan length in cycles.
    function automatic int build(input int k, input int nent);
        int s = 0;
        int l;
        int w;
        ex_n[k]  = 0;
        got_n[k] = 0;
        for (int i = 0; i < nent; i++) begin
            l = (crl[k][i] == 0) ? TMO : crl[k][i];
            add_txn(k, 1'b0, alist[k][i], cd[k][i], l, crl[k][i] != 0);
            if (crl[k][i] == 0) s += 2 + TMO;
            else if (wb[k]) begin
                w = (cwl[k][i] == 0) ? TMO : cwl[k][i];
                add_txn(k, 1'b1, alist[k][i], cd[k][i], w, 1'b0);
                s += 3 + l + w;
            end else s += 2 + l;
        end
        return s;
    endfunction

    // Scan outcome derived from the entry rules.
    task automatic model_status(input int k, output logic [3:0] m, output bit t, output logic [31:0] l);
        m = 4'b0; t = 1'b0; l = exp_last[k];
        for (int i = 0; i < 4; i++) begin
            if (crl[k][i] == 0) begin m[i] = 1'b1; t = 1'b1; end
            else begin
                l = cd[k][i];
                if (cd[k][i] == 32'd0) m[i] = 1'b1;
                if (wb[k] && cwl[k][i] == 0) begin m[i] = 1'b1; t = 1'b1; end
            end
        end
    endtask

    task automatic do_scan(input int k, input logic [3:0] em, input bit ep, input bit et,
                           input logic [31:0] el, input string tag);
        int  s;
        int  st;
        bit  ok;
        s = build(k, 4);
        done_cnt[k] = 0;
        @(negedge usr_clk);
        run[k] = 1'b1;
        st = cyc;
        @(negedge usr_clk);
        check($sformatf("%s start busy/mask/pass/tmo", tag), {busy[k], mask[k], pass[k], tmo[k]}, 7'b1000000);
        ok = 1'b0;
        for (int n = 0; n < 600 && !ok; n++) begin
            @(negedge usr_clk);
            if (done_cnt[k] != 0) ok = 1'b1;
        end
        check($sformatf("%s done seen", tag), ok, 1'b1);
        repeat (3) @(negedge usr_clk);
        run[k] = 1'b0;
        @(negedge usr_clk);
        check($sformatf("%s done pulses", tag), done_cnt[k], 1);
        check($sformatf("%s done cycle", tag), done_cyc[k], st + 1 + s);
        check($sformatf("%s fail_mask", tag), mask[k], em);
        check($sformatf("%s pass", tag), pass[k], ep);
        check($sformatf("%s timeout", tag), tmo[k], et);
        check($sformatf("%s last_rd", tag), last[k], el);
        check($sformatf("%s strobe count", tag), got_n[k], ex_n[k]);
        check($sformatf("%s busy end", tag), busy[k], 1'b0);
        exp_last[k] = el;
    endtask

    initial begin
        usr_clk = 1'b0;
        forever #5 usr_clk = ~usr_clk;
    end

    initial forever begin
        @(posedge usr_clk);
        cyc++;
    end

    // Behavioural completer: done after the configured latency (0 = never),
    // optional spurious done pulses while no strobe is high.
    initial begin : resp
        int age [2];
        int lat;
        int e;
        age[0] = 0;
        age[1] = 0;
        forever begin
            @(negedge usr_clk);
            for (int k = 0; k < 2; k++) begin
                if (rd[k] || wr[k]) begin
                    age[k]++;
                    e = idx_of(k, addr[k]);
                    lat = rd[k] ? crl[k][e] : cwl[k][e];
                    done[k] = (lat != 0) && (age[k] == lat);
                    rdata[k] = done[k] ? cd[k][e] : $urandom();
                end else begin
                    age[k] = 0;
                    done[k] = spur[k] && ($urandom_range(0, 1) == 1);
                    rdata[k] = $urandom();
                end
            end
        end
    end

    // Strobe monitor: checks each finished strobe against the expected list.
    initial begin : mon
        int          hi  [2];
        bit          prev[2];
        bit          cw  [2];
        logic [18:0] ca  [2];
        logic [31:0] cdw [2];
        txn_t        e;
        for (int k = 0; k < 2; k++) begin
            hi[k] = 0; prev[k] = 1'b0; cw[k] = 1'b0; ca[k] = '0; cdw[k] = '0;
        end
        forever begin
            @(negedge usr_clk);
            for (int k = 0; k < 2; k++) begin
                check("be/type1/strobe overlap", {be[k], type1[k], rd[k] & wr[k]},
                      {(wr[k] ? 4'hF : 4'h0), 1'b0, 1'b0});
                if (sdone[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                    check("busy with done pulse", busy[k], 1'b0);
                end
                if (rd[k] || wr[k]) begin
                    if (!prev[k]) begin
                        hi[k] = 1; cw[k] = wr[k]; ca[k] = addr[k]; cdw[k] = wdata[k];
                    end else hi[k]++;
                end else if (prev[k]) begin
                    if (got_n[k] >= ex_n[k]) check("unexpected strobe", 1'b1, 1'b0);
                    else begin
                        e = ex[k][got_n[k]];
                        check("strobe kind", cw[k], e.w);
                        check("strobe addr", ca[k], e.a);
                        check("strobe length", hi[k], e.dur);
                        if (e.w) check("write data", cdw[k], e.d);
                        if (!e.w && e.cl) check("last_rd at strobe fall", last[k], e.d);
                    end
                    got_n[k]++;
                end
                prev[k] = rd[k] || wr[k];
            end
        end
    end

    initial begin : main
        vec_t        vt [9];
        logic [3:0]  m;
        bit          t;
        logic [31:0] l;
        bit          ok;
        int          s;
        int          k;

        alist[0] = '{19'd0, 19'd4, 19'd16, 19'd60};
        alist[1] = '{19'd8, 19'd4, 19'd16, 19'd12};
        wb[0] = 1'b1;
        wb[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            run[j] = 1'b0; done[j] = 1'b0; rdata[j] = '0; spur[j] = 1'b0;
            exp_last[j] = '0; ex_n[j] = 0; got_n[j] = 0; done_cnt[j] = 0; done_cyc[j] = 0;
            for (int i = 0; i < 4; i++) begin cd[j][i] = 32'h1FF; crl[j][i] = 3; cwl[j][i] = 3; end
        end

        vt[0] = '{0, {4{32'h0000_01FF}}, 16'h3333, 16'h3333, 1'b0, 4'b0000, 1'b1, 1'b0};
        vt[1] = '{0, {32'h1FF, 32'h0, 32'h1FF, 32'h1FF}, 16'h3333, 16'h3333, 1'b0, 4'b0100, 1'b0, 1'b0};
        vt[2] = '{0, {4{32'h0000_01FF}}, 16'h3303, 16'h3333, 1'b0, 4'b0010, 1'b0, 1'b1};
        vt[3] = '{0, {4{32'h0000_01FF}}, 16'h3333, 16'h0333, 1'b0, 4'b1000, 1'b0, 1'b1};
        vt[4] = '{0, {32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'hA5A5_0001}, 16'h1111, 16'h1111, 1'b1, 4'b0000, 1'b1, 1'b0};
        vt[5] = '{0, {32'h1FF, 32'h1FF, 32'h1FF, 32'h0}, 16'h0777, 16'h7777, 1'b0, 4'b1001, 1'b0, 1'b1};
        vt[6] = '{1, {4{32'h0000_01FF}}, 16'h3333, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vt[7] = '{1, {32'h0, 32'h1FF, 32'h1FF, 32'h1FF}, 16'h3303, 16'h0000, 1'b0, 4'b1010, 1'b0, 1'b1};
        vt[8] = '{1, {4{32'h0}}, 16'h2222, 16'h0000, 1'b1, 4'b1111, 1'b0, 1'b0};

        usr_rst_n = 1'b1;
        #2 usr_rst_n = 1'b0;
        repeat (3) @(negedge usr_clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("reset addr %0d", j), addr[j], alist[j][0]);
            check($sformatf("reset strobes/status %0d", j),
                  {rd[j], wr[j], busy[j], sdone[j], pass[j], tmo[j], mask[j], be[j]}, 14'd0);
            check($sformatf("reset data %0d", j), wdata[j] | last[j], 32'd0);
        end
        usr_rst_n = 1'b1;
        repeat (2) @(negedge usr_clk);

        // Directed scans from the vector table.
        for (int i = 0; i < 9; i++) begin
            k = vt[i].k;
            for (int e = 0; e < 4; e++) begin
                cd[k][e] = vt[i].d[e]; crl[k][e] = int'(vt[i].rl[e]); cwl[k][e] = int'(vt[i].wl[e]);
            end
            spur[k] = vt[i].spur;
            model_status(k, m, t, l);
            do_scan(k, vt[i].emask, vt[i].epass, vt[i].etmo, l, $sformatf("vec%0d", i));
        end
        spur[0] = 1'b0;
        spur[1] = 1'b0;

        // Abort during the read of entry 2; entry 0 reads zero so the mask is partial.
        for (int e = 0; e < 4; e++) begin cd[0][e] = 32'h1FF; crl[0][e] = 3; cwl[0][e] = 3; end
        cd[0][0] = 32'h0;
        crl[0][2] = 0;
        s = build(0, 2);
        add_txn(0, 1'b0, 19'd16, 32'h0, 3, 1'b0);
        done_cnt[0] = 0;
        @(negedge usr_clk);
        run[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge usr_clk);
            if (rd[0] && addr[0] == 19'd16) ok = 1'b1;
        end
        check("abort reached entry 2", ok, 1'b1);
        repeat (2) @(negedge usr_clk);
        run[0] = 1'b0;
        @(negedge usr_clk);
        check("abort read drop", rd[0], 1'b0);
        check("abort busy drop", busy[0], 1'b0);
        repeat (10) @(negedge usr_clk);
        check("abort no done", done_cnt[0], 0);
        check("abort pass", pass[0], 1'b0);
        check("abort partial mask", mask[0], 4'b0001);
        check("abort timeout", tmo[0], 1'b0);
        check("abort strobe count", got_n[0], ex_n[0]);
        check("abort addr back to entry 0", addr[0], 19'd0);
        exp_last[0] = 32'h1FF;

        // Restart after abort begins at entry 0 with a cleared mask.
        cd[0][0] = 32'h1FF;
        crl[0][2] = 3;
        model_status(0, m, t, l);
        do_scan(0, 4'b0000, 1'b1, 1'b0, l, "restart");

        // Reset in the middle of the first write-back.
        cwl[0][0] = 5;
        s = build(0, 0);
        add_txn(0, 1'b0, 19'd0, 32'h1FF, 3, 1'b1);
        add_txn(0, 1'b1, 19'd0, 32'h1FF, 1, 1'b0);
        @(negedge usr_clk);
        run[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge usr_clk);
            if (wr[0]) ok = 1'b1;
        end
        check("reset test reached write", ok, 1'b1);
        #2 usr_rst_n = 1'b0;
        #1;
        check("mid-write reset strobes/busy", {rd[0], wr[0], busy[0], be[0]}, 7'd0);
        check("mid-write reset data", last[0] | wdata[0], 32'd0);
        @(negedge usr_clk);
        run[0] = 1'b0;
        repeat (2) @(negedge usr_clk);
        usr_rst_n = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge usr_clk);
            if (rd[0] || wr[0] || busy[0]) ok = 1'b1;
        end
        check("idle after reset release", ok, 1'b0);
        check("reset strobe count", got_n[0], ex_n[0]);
        exp_last[0] = 32'd0;
        cwl[0][0] = 3;

        // Randomised scans checked against the model.
        for (int r = 0; r < 16; r++) begin
            k = $urandom_range(0, 1);
            for (int e = 0; e < 4; e++) begin
                cd[k][e]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
                crl[k][e] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
                cwl[k][e] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
            end
            spur[k] = ($urandom_range(0, 1) == 1);
            model_status(k, m, t, l);
            do_scan(k, m, m == 4'b0, t, l, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
